aes_round_ctrl: RTL and testbench

Round sequencer for the AES-128 encryption datapath. Accepts one block-start request at a time through a valid/ready handshake, then drives the state-register load, round-enable and final-round-bypass controls around the registered `mix_column` stage (fixed 1-cycle latency by default), steps the round index used by key expansion, and presents a completion handshake. It holds no data; the datapath (`sub_bytes`/`shift_rows` → `mix_column` → add-round-key → state register) consumes its control outputs.

---
 rtl/aes_round_ctrl.sv | 120 ++++++++++++
 tb/tb_aes_round_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the AES-128 encryption datapath: drives state-register
// load, round-enable and final-round bypass around a registered mix_column stage.
module aes_round_ctrl #(
  parameter int NROUNDS = 10,
  parameter int MIX_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       dp_load,
  output logic       dp_round_en,
  output logic       dp_final,
  output logic [3:0] round_num,
  output logic       busy
);

  // state | meaning
  // IDLE  | waiting for a block request
  // LOAD  | state register <- plaintext ^ key
  // MIX   | waiting MIX_LAT cycles for the mix_column register
  // ADDKEY| state register <- add-round-key output
  // FINAL | last round, mix_column bypassed
  // DONE  | ciphertext valid, waiting for consumer
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MIX, S_ADDKEY, S_FINAL, S_DONE
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS - 1);
  localparam logic [3:0] ROUND_MAX  = 4'(NROUNDS);
  localparam logic [1:0] MIX_LAST   = 2'(MIX_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [1:0] mix_cnt_q, mix_cnt_d;
  logic       idle_q, out_valid_q, load_q, round_en_q, final_q, busy_q;
  logic       accept;

  // out_valid_q is high exactly in DONE, so this is IDLE | (DONE & out_ready)
  assign in_ready = idle_q | (out_valid_q & out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    mix_cnt_d = mix_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d   = S_MIX;
        round_d   = 4'd1;
        mix_cnt_d = 2'd0;
      end
      S_MIX: begin
        mix_cnt_d = mix_cnt_q + 2'd1;
        if (mix_cnt_q == MIX_LAST) state_d = S_ADDKEY;
      end
      S_ADDKEY: begin
        if (round_q == LAST_ROUND) begin
          state_d = S_FINAL;
          round_d = ROUND_MAX;
        end else begin
          state_d   = S_MIX;
          round_d   = round_q + 4'd1;
          mix_cnt_d = 2'd0;
        end
      end
      S_FINAL: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = in_valid ? S_LOAD : S_IDLE;
          round_d = 4'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      round_q     <= 4'd0;
      mix_cnt_q   <= 2'd0;
      idle_q      <= 1'b1;
      out_valid_q <= 1'b0;
      load_q      <= 1'b0;
      round_en_q  <= 1'b0;
      final_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      mix_cnt_q   <= mix_cnt_d;
      idle_q      <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
      load_q      <= (state_d == S_LOAD);
      round_en_q  <= (state_d == S_ADDKEY) || (state_d == S_FINAL);
      final_q     <= (state_d == S_FINAL);
      busy_q      <= (state_d == S_LOAD) || (state_d == S_MIX) ||
                     (state_d == S_ADDKEY) || (state_d == S_FINAL);
    end
  end

  assign out_valid   = out_valid_q;
  assign dp_load     = load_q;
  assign dp_round_en = round_en_q;
  assign dp_final    = final_q;
  assign round_num   = round_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Randomized bench for aes_round_ctrl: default instance and an NROUNDS=2,
// MIX_LAT=3 instance, both checked per cycle against a cycle-offset model.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] iv;
  logic [1:0] ordy;

  logic [1:0] ir, ov, ld, ren, fin, bsy;
  logic [3:0] rn0, rn1;
  logic [9:0] obs [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  localparam logic [9:0] IDLE_V = 10'b10_0000_0000;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_round_ctrl dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .dp_load(ld[0]),
    .dp_round_en(ren[0]), .dp_final(fin[0]), .round_num(rn0), .busy(bsy[0])
  );

  aes_round_ctrl #(.NROUNDS(2), .MIX_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .dp_load(ld[1]),
    .dp_round_en(ren[1]), .dp_final(fin[1]), .round_num(rn1), .busy(bsy[1])
  );

  assign obs[0] = {ir[0], ov[0], ld[0], ren[0], fin[0], bsy[0], rn0};
  assign obs[1] = {ir[1], ov[1], ld[1], ren[1], fin[1], bsy[1], rn1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int nr_of(input int i);
    return (i == 0) ? 10 : 2;
  endfunction

  function automatic int ml_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Expected {in_ready,out_valid,load,round_en,final,busy,round} t cycles after
  // the accept edge (t=1 is LOAD), with out_ready low while in DONE.
  function automatic logic [9:0] mdl(input int nr, input int ml, input int t);
    int f;
    int ph;
    int r;
    f = 2 + (nr - 1) * (ml + 1);
    if (t == 1) return {6'b00_1001, 4'd0};
    if (t < f) begin
      ph = (t - 2) % (ml + 1);
      r  = (t - 2) / (ml + 1) + 1;
      return {3'b000, (ph == ml), 2'b01, 4'(r)};
    end
    if (t == f) return {6'b00_0111, 4'(nr)};
    return {6'b01_0000, 4'(nr)};
  endfunction

  task automatic run_blocks(input int i, input int nblk);
    int  nr, ml, f, stall, prev_stall, prev_ov;
    bit  b2b;
    nr = nr_of(i);
    ml = ml_of(i);
    f  = 2 + (nr - 1) * (ml + 1);
    b2b = 1'b0;
    prev_ov = -1;
    prev_stall = 0;
    for (int k = 0; k < nblk; k++) begin
      if (!b2b) begin
        @(negedge clk);
        iv[i]   = 1'b1;
        ordy[i] = 1'($urandom);
        #1 chk($sformatf("u%0d accept_rdy", i), 32'(obs[i][9]), 32'd1);
      end
      for (int t = 1; t <= f; t++) begin
        @(negedge clk);
        chk($sformatf("u%0d blk%0d t%0d", i, k, t), 32'(obs[i]), 32'(mdl(nr, ml, t)));
        iv[i]   = 1'($urandom);
        ordy[i] = 1'($urandom);
      end
      stall = $urandom_range(0, 5);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        ordy[i] = 1'b0;
        iv[i]   = 1'($urandom);
        #1 chk($sformatf("u%0d done_hold%0d", i, s), 32'(obs[i]), 32'(mdl(nr, ml, f + 1)));
        if (s == 0) begin
          if (b2b) chk($sformatf("u%0d ov_gap", i), 32'(cyc - prev_ov), 32'(prev_stall + f + 1));
          prev_ov = cyc;
        end
      end
      @(negedge clk);
      if (stall == 0) begin
        if (b2b) chk($sformatf("u%0d ov_gap", i), 32'(cyc - prev_ov), 32'(prev_stall + f + 1));
        prev_ov = cyc;
      end
      b2b     = (k < nblk - 1) && ($urandom_range(0, 1) == 1);
      ordy[i] = 1'b1;
      iv[i]   = b2b;
      #1 chk($sformatf("u%0d done_hs", i), 32'(obs[i]), 32'(mdl(nr, ml, f + 1) | IDLE_V));
      prev_stall = stall;
      if (!b2b) begin
        @(negedge clk);
        iv[i]   = 1'b0;
        ordy[i] = 1'b0;
        #1 chk($sformatf("u%0d back_idle", i), 32'(obs[i]), 32'(IDLE_V));
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    iv   = 2'b11;
    ordy = 2'b00;

    // Reset held with in_valid high: must stay idle.
    repeat (2) begin
      @(negedge clk);
      chk("rst_idle_u0", 32'(obs[0]), 32'(IDLE_V));
      chk("rst_idle_u1", 32'(obs[1]), 32'(IDLE_V));
    end
    rst = 1'b0;
    iv  = 2'b00;
    @(negedge clk);
    chk("post_rst_u0", 32'(obs[0]), 32'(IDLE_V));

    run_blocks(0, 12);

    // Reset in the middle of a block discards it.
    @(negedge clk);
    iv[0] = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      chk($sformatf("pre_rst t%0d", t), 32'(obs[0]), 32'(mdl(10, 1, t)));
      iv[0] = 1'b0;
    end
    rst   = 1'b1;
    iv[0] = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    iv[0] = 1'b0;
    chk("rst_mid_idle", 32'(obs[0]), 32'(IDLE_V));
    run_blocks(0, 2);

    run_blocks(1, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
